sdram_write_burst: RTL and testbench

Parametrised successor to the single-bank, fixed-timing SDRAM write engine. It issues multi-burst SDRAM writes through the command arbiter with:
- a parametrised data, row, column and bank geometry;
- programmable tRCD/tWR/tRP waits;
- automatic row-crossing (close row, open next) and bank/row carry;
- preemption by the arbiter (e.g. refresh) with resume at the saved address.
It sits between the write-data FIFO and the SDRAM command mux, beside the read and refresh engines.

---
 rtl/sdram_pkg.sv | 34 +++
 rtl/sdram_wait_cnt.sv | 28 ++
 rtl/sdram_write_burst.sv | 239 +++++++++++++++++++++++
 tb/tb_sdram_write_burst.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, write-engine state codes
// and a generic address field extractor.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ASK  = 3'd1;
  localparam logic [2:0] ST_ACT  = 3'd2;
  localparam logic [2:0] ST_RCD  = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;
  localparam logic [2:0] ST_TWR  = 3'd5;
  localparam logic [2:0] ST_PRE  = 3'd6;
  localparam logic [2:0] ST_RP   = 3'd7;

  localparam int unsigned A10_BIT = 10;
  localparam int unsigned WAIT_W  = 8;

  // Extract 'width' bits starting at 'lsb' from a packed {bank,row,col} address.
  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// Loadable down-counter; done is high while the count sits at zero, so a
// load of N-1 gives a wait of exactly N cycles.
module sdram_wait_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sdram_write_burst.sv
// Multi-burst SDRAM write engine: requests the bus, opens rows, streams
// BL-word bursts from a FWFT FIFO, crosses rows and yields to the arbiter
// at burst boundaries, resuming at the saved address.
module sdram_write_burst
  import sdram_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned ROW_W  = 12,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned BL     = 4,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned T_RCD  = 2,
  parameter int unsigned T_WR   = 2,
  parameter int unsigned T_RP   = 2
) (
  input  logic                            sclk,
  input  logic                            srst_n,
  input  logic                            wr_trig,
  input  logic [LEN_W-1:0]                wr_len,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_addr,
  input  logic                            wr_en,
  output logic                            wr_ask,
  output logic                            wr_done,
  output logic                            busy,
  input  logic [DW-1:0]                   wr_data,
  output logic                            wr_data_en,
  output logic [3:0]                      sdram_cmd,
  output logic [BANK_W-1:0]               sdram_bank,
  output logic [ROW_W-1:0]                sdram_addr,
  output logic [DW-1:0]                   sdram_dq,
  output logic                            sdram_dq_oe
);

  localparam int unsigned BR_W   = BANK_W + ROW_W;
  localparam int unsigned BEAT_W = $clog2(BL);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BL - 1);
  localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BL);
  localparam logic [COL_W-1:0]  COL_ALIGN = ~COL_W'(BL - 1);
  localparam logic [ROW_W-1:0]  A10_MASK  = ROW_W'(1) << A10_BIT;
  localparam logic [WAIT_W-1:0] RCD_VAL   = WAIT_W'(T_RCD - 1);
  localparam logic [WAIT_W-1:0] TWR_VAL   = WAIT_W'(T_WR - 1);
  localparam logic [WAIT_W-1:0] RP_VAL    = WAIT_W'(T_RP - 1);

  logic [2:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [BR_W-1:0]   bkrow_q, bkrow_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic              den_q, oe_q, den_d;

  logic              wait_load, wait_done;
  logic [WAIT_W-1:0] wait_val;

  logic [COL_W-1:0]  trig_col, col_next;
  logic [BR_W-1:0]   trig_bkrow;
  logic [LEN_W-1:0]  rem_next;
  logic [BANK_W-1:0] cur_bank;
  logic [ROW_W-1:0]  cur_row;

  assign trig_col   = COL_W'(addr_field(64'(wr_addr), 0, COL_W)) & COL_ALIGN;
  assign trig_bkrow = BR_W'(addr_field(64'(wr_addr), COL_W, BR_W));
  assign cur_bank   = bkrow_q[BR_W-1:ROW_W];
  assign cur_row    = bkrow_q[ROW_W-1:0];
  assign col_next   = col_q + COL_STEP;
  assign rem_next   = (rem_q == '0) ? '0 : rem_q - 1'b1;

  sdram_wait_cnt #(
    .W (WAIT_W)
  ) u_wait (
    .clk      (sclk),
    .rst_n    (srst_n),
    .load     (wait_load),
    .load_val (wait_val),
    .done     (wait_done)
  );

  // Next-state, address bookkeeping and next registered command outputs.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    bkrow_d   = bkrow_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    wrap_d    = wrap_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cmd_d     = CMD_NOP;
    bank_d    = bank_q;
    addr_d    = addr_q;
    den_d     = 1'b0;
    wait_load = 1'b0;
    wait_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (wr_trig && (wr_len != '0)) begin
          col_d   = trig_col;
          bkrow_d = trig_bkrow;
          rem_d   = wr_len;
          wrap_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_ASK;
        end
      end
      ST_ASK: begin
        if (wr_en) begin
          state_d = ST_ACT;
          cmd_d   = CMD_ACT;
          bank_d  = cur_bank;
          addr_d  = cur_row;
        end
      end
      ST_ACT: begin
        state_d   = ST_RCD;
        wait_load = 1'b1;
        wait_val  = RCD_VAL;
      end
      ST_RCD: begin
        if (wait_done) begin
          state_d = ST_WR;
          beat_d  = '0;
          wrap_d  = 1'b0;
          cmd_d   = CMD_WRITE;
          bank_d  = cur_bank;
          addr_d  = ROW_W'(col_q) & ~A10_MASK;
          den_d   = 1'b1;
        end
      end
      ST_WR: begin
        if (beat_q == BEAT_LAST) begin
          // Burst boundary: advance address, then chain, or close the row.
          col_d  = col_next;
          rem_d  = rem_next;
          wrap_d = (col_next == '0);
          if (col_next == '0) begin
            bkrow_d = bkrow_q + 1'b1;
          end
          if ((rem_next != '0) && wr_en && (col_next != '0)) begin
            beat_d = '0;
            cmd_d  = CMD_WRITE;
            bank_d = cur_bank;
            addr_d = ROW_W'(col_next) & ~A10_MASK;
            den_d  = 1'b1;
          end else begin
            state_d   = ST_TWR;
            wait_load = 1'b1;
            wait_val  = TWR_VAL;
          end
        end else begin
          beat_d = beat_q + 1'b1;
          den_d  = 1'b1;
        end
      end
      ST_TWR: begin
        if (wait_done) begin
          state_d = ST_PRE;
          cmd_d   = CMD_PRE;
          bank_d  = '0;
          addr_d  = A10_MASK;
        end
      end
      ST_PRE: begin
        state_d   = ST_RP;
        wait_load = 1'b1;
        wait_val  = RP_VAL;
      end
      ST_RP: begin
        if (wait_done) begin
          if (rem_q == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else if (wrap_q && wr_en) begin
            // Row crossing while still granted: open the next row directly.
            state_d = ST_ACT;
            cmd_d   = CMD_ACT;
            bank_d  = cur_bank;
            addr_d  = cur_row;
          end else begin
            // Yield the bus; address and count are kept for the resume.
            done_d  = 1'b1;
            state_d = ST_ASK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts without issuing PRE.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      bkrow_q <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cmd_q   <= CMD_NOP;
      bank_q  <= '0;
      addr_q  <= '0;
      den_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      bkrow_q <= bkrow_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      den_q   <= den_d;
      oe_q    <= den_d;
    end
  end

  assign wr_ask      = (state_q == ST_ASK);
  assign wr_done     = done_q;
  assign busy        = busy_q;
  assign wr_data_en  = den_q;
  assign sdram_cmd   = cmd_q;
  assign sdram_bank  = bank_q;
  assign sdram_addr  = addr_q;
  assign sdram_dq    = wr_data;
  assign sdram_dq_oe = oe_q;

endmodule

// File: tb/tb_sdram_write_burst.sv
// Bench for sdram_write_burst: directed and random transactions checked
// against an expected command/timing list built from the write rules.
module tb_sdram_write_burst;
  import sdram_pkg::*;

  localparam int DW = 16, ROW_W = 12, COL_W = 9, BANK_W = 2, BL = 4, LEN_W = 8;
  localparam int T_RCD = 2, T_WR = 2, T_RP = 2;
  localparam int AW = BANK_W + ROW_W + COL_W;
  localparam int K_ACT = 1, K_WR = 2, K_PRE = 3, K_DONE = 4, K_BAD = 9;

  typedef struct {
    int kind;
    int bank;
    int addr;
    int delta;
    int bsy;
  } ev_t;

  logic              sclk = 1'b0;
  logic              srst_n = 1'b0;
  logic              wr_trig = 1'b0;
  logic [LEN_W-1:0]  wr_len = '0;
  logic [AW-1:0]     wr_addr = '0;
  logic              wr_en = 1'b0;
  logic              wr_ask, wr_done, busy, wr_data_en, sdram_dq_oe;
  logic [DW-1:0]     wr_data, sdram_dq;
  logic [3:0]        sdram_cmd;
  logic [BANK_W-1:0] sdram_bank;
  logic [ROW_W-1:0]  sdram_addr;

  logic [DW-1:0] data_mem [1024];
  logic [31:0]   rd_ptr = '0;
  int            total = 0;
  int            bad = 0;
  int            exp_ptr;
  ev_t           exp_q[$];
  ev_t           got_q[$];

  sdram_write_burst #(
    .DW(DW), .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .BL(BL), .LEN_W(LEN_W),
    .T_RCD(T_RCD), .T_WR(T_WR), .T_RP(T_RP)
  ) dut (
    .sclk        (sclk),
    .srst_n      (srst_n),
    .wr_trig     (wr_trig),
    .wr_len      (wr_len),
    .wr_addr     (wr_addr),
    .wr_en       (wr_en),
    .wr_ask      (wr_ask),
    .wr_done     (wr_done),
    .busy        (busy),
    .wr_data     (wr_data),
    .wr_data_en  (wr_data_en),
    .sdram_cmd   (sdram_cmd),
    .sdram_bank  (sdram_bank),
    .sdram_addr  (sdram_addr),
    .sdram_dq    (sdram_dq),
    .sdram_dq_oe (sdram_dq_oe)
  );

  always #5 sclk = ~sclk;

  // FWFT FIFO model: head word presented, popped on wr_data_en.
  assign wr_data = data_mem[rd_ptr[9:0]];
  always @(posedge sclk) if (wr_data_en === 1'b1) rd_ptr <= rd_ptr + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int kind, input int bank, input int addr, input int delta,
                          input int bsy);
    ev_t e;
    e.kind = kind; e.bank = bank; e.addr = addr; e.delta = delta; e.bsy = bsy;
    exp_q.push_back(e);
  endtask

  // Expected command list: bursts grouped per open row, with the required
  // spacing to the previous event (-1 = not constrained).
  task automatic build_exp(input int bank, input int row, input int col, input int len,
                           input int yield_after);
    int bkrow, c, rem, k, act_delta;
    bit need_act, wrap;
    exp_q.delete();
    bkrow = bank * (1 << ROW_W) + row;
    c = col - (col % BL);
    rem = len; k = 0; need_act = 1; act_delta = -1;
    while (rem > 0) begin
      if (need_act) begin
        push_exp(K_ACT, bkrow / (1 << ROW_W), bkrow % (1 << ROW_W), act_delta, 0);
        push_exp(K_WR, bkrow / (1 << ROW_W), c, T_RCD + 1, 0);
        need_act = 0;
      end else begin
        push_exp(K_WR, bkrow / (1 << ROW_W), c, BL, 0);
      end
      rem--; k++;
      c += BL;
      wrap = (c == (1 << COL_W));
      if (wrap) begin
        c = 0;
        bkrow = (bkrow + 1) % (1 << (BANK_W + ROW_W));
      end
      if (rem == 0) begin
        push_exp(K_PRE, 0, 1, BL + T_WR, 0);
        push_exp(K_DONE, 0, 0, T_RP + 1, 0);
      end else if (k == yield_after) begin
        push_exp(K_PRE, 0, 1, BL + T_WR, 0);
        push_exp(K_DONE, 0, 0, T_RP + 1, 1);
        need_act = 1; act_delta = -1;
      end else if (wrap) begin
        push_exp(K_PRE, 0, 1, BL + T_WR, 0);
        need_act = 1; act_delta = T_RP + 1;
      end
    end
  endtask

  task automatic record(input int kind, input int bank, input int addr, input int cyc,
                        input int bsy);
    ev_t e;
    e.kind = kind; e.bank = bank; e.addr = addr; e.delta = cyc; e.bsy = bsy;
    got_q.push_back(e);
  endtask

  task automatic run_txn(input int bank, input int row, input int col, input int len,
                         input int yield_after, input bit inject);
    int cyc, last_w, nwr, words, ask_cnt, n, prev;
    bit dropped, restored, finished, saw_ask, exp_den;
    build_exp(bank, row, col, len, yield_after);
    got_q.delete();
    @(negedge sclk);
    exp_ptr = int'(rd_ptr);
    wr_addr = AW'((bank << (ROW_W + COL_W)) | (row << COL_W) | col);
    wr_len = LEN_W'(len);
    wr_trig = 1'b1;
    wr_en = 1'b1;
    @(negedge sclk);
    wr_trig = 1'b0;
    cyc = 0; last_w = -1000; nwr = 0; words = 0; ask_cnt = 0;
    dropped = 0; restored = 0; finished = 0; saw_ask = 0;
    while (!finished && cyc < 3000) begin
      if (sdram_cmd === CMD_ACT) record(K_ACT, int'(sdram_bank), int'(sdram_addr), cyc, 0);
      else if (sdram_cmd === CMD_WRITE) begin
        record(K_WR, int'(sdram_bank), int'(sdram_addr), cyc, 0);
        last_w = cyc; nwr++;
      end else if (sdram_cmd === CMD_PRE) record(K_PRE, 0, int'(sdram_addr[10]), cyc, 0);
      else if (sdram_cmd !== CMD_NOP) record(K_BAD, 0, int'(sdram_cmd), cyc, 0);
      if (wr_done === 1'b1) begin
        record(K_DONE, 0, 0, cyc, int'(busy));
        if (busy === 1'b0) finished = 1;
      end
      exp_den = (cyc - last_w) < BL;
      check("data_en", wr_data_en, exp_den);
      check("dq_oe", sdram_dq_oe, exp_den);
      if (exp_den) begin
        check("dq", sdram_dq, data_mem[exp_ptr % 1024]);
        exp_ptr++; words++;
      end
      wr_trig = (inject && cyc == 3);
      if (inject && cyc == 3) begin
        wr_addr = AW'('h155555);
        wr_len = LEN_W'(5);
      end
      if (yield_after > 0 && !dropped && nwr == yield_after) begin
        wr_en = 1'b0; dropped = 1;
      end
      if (dropped && !restored && wr_ask === 1'b1) begin
        if (!saw_ask) check("busy_while_yield", busy, 1);
        saw_ask = 1;
        ask_cnt++;
        if (ask_cnt == 3) begin
          wr_en = 1'b1; restored = 1;
        end
      end
      @(negedge sclk);
      cyc++;
    end
    wr_trig = 1'b0;
    check("txn_finished", finished, 1);
    check("word_count", words, len * BL);
    if (yield_after > 0) check("ask_on_yield", saw_ask, 1);
    check("event_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    prev = 0;
    for (int i = 0; i < n; i++) begin
      check("ev_kind", got_q[i].kind, exp_q[i].kind);
      if (exp_q[i].kind == K_ACT || exp_q[i].kind == K_WR) begin
        check("ev_bank", got_q[i].bank, exp_q[i].bank);
      end
      if (exp_q[i].kind != K_DONE) check("ev_addr", got_q[i].addr, exp_q[i].addr);
      else check("done_busy", got_q[i].bsy, exp_q[i].bsy);
      if (exp_q[i].delta >= 0) check("ev_spacing", got_q[i].delta - prev, exp_q[i].delta);
      prev = got_q[i].delta;
    end
    @(negedge sclk);
    check("idle_busy", busy, 0);
    check("idle_cmd", sdram_cmd, CMD_NOP);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd"}, sdram_cmd, CMD_NOP);
    check({tag, "_bank"}, sdram_bank, 0);
    check({tag, "_addr"}, sdram_addr, 0);
    check({tag, "_den"}, wr_data_en, 0);
    check({tag, "_oe"}, sdram_dq_oe, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, wr_done, 0);
    check({tag, "_ask"}, wr_ask, 0);
  endtask

  initial begin
    int nonnop, busy_hi, ln, bk, rw, cl, ya;
    for (int i = 0; i < 1024; i++) data_mem[i] = DW'($urandom);
    repeat (3) @(negedge sclk);
    check_reset_vals("reset");
    srst_n = 1'b1;
    @(negedge sclk);

    run_txn(0, 'h123, 'h010, 1, 0, 0);   // single burst
    run_txn(0, 'h000, 'h000, 3, 0, 1);   // back-to-back, ignored re-trigger
    run_txn(1, 'hFFF, 'h1FC, 2, 0, 0);   // row crossing with bank/row carry
    run_txn(0, 'h005, 'h000, 4, 2, 0);   // preemption after burst 2
    run_txn(3, 'h007, 'h013, 1, 0, 0);   // misaligned column

    // Zero-length trigger is a no-op.
    @(negedge sclk);
    wr_len = '0; wr_addr = AW'('h012345); wr_trig = 1'b1;
    @(negedge sclk);
    wr_trig = 1'b0;
    nonnop = 0; busy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (sdram_cmd !== CMD_NOP) nonnop++;
      if (busy !== 1'b0) busy_hi++;
      @(negedge sclk);
    end
    check("len0_cmds", nonnop, 0);
    check("len0_busy", busy_hi, 0);

    // Asynchronous reset in the middle of a burst.
    wr_len = LEN_W'(4); wr_addr = AW'('h0A0000); wr_en = 1'b1; wr_trig = 1'b1;
    @(negedge sclk);
    wr_trig = 1'b0;
    for (int i = 0; i < 50 && wr_data_en !== 1'b1; i++) @(negedge sclk);
    check("reach_wr", wr_data_en, 1);
    #2 srst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge sclk);
    check_reset_vals("held_rst");
    srst_n = 1'b1;
    run_txn(2, 'h040, 'h020, 2, 0, 0);

    // Random transactions, some near row ends, some with preemption.
    for (int t = 0; t < 10; t++) begin
      bk = int'($urandom_range(0, 3));
      rw = int'($urandom_range(0, 4095));
      cl = int'($urandom_range(0, 511));
      ln = int'($urandom_range(1, 6));
      if ($urandom_range(0, 2) == 0) begin
        cl = 512 - BL * int'($urandom_range(1, 2));
        if ($urandom_range(0, 1) == 1) rw = 4095;
      end
      ya = 0;
      if (ln > 1 && $urandom_range(0, 1) == 1) ya = int'($urandom_range(1, ln - 1));
      run_txn(bk, rw, cl, ln, ya, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
